// File: rtl/ucdp_clk_gate_ctrl_pkg.sv
// Shared types and helpers for the idle-based clock-gating controller.
package ucdp_clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAKE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GATED = 2'd2
    } gate_state_e;

    localparam int DefaultIdleWidth  = 8;
    localparam int DefaultWakeCycles = 2;
    localparam int DefaultStatWidth  = 16;

    // Counter must be able to hold WakeCycles; never narrower than one bit.
    function automatic int wake_cnt_width(input int wake_cycles);
        return (wake_cycles < 1) ? 1 : $clog2(wake_cycles + 1);
    endfunction

endpackage

// File: rtl/ucdp_clk_gate_ctrl.sv
// Idle-based clock-gating controller driving the enable of a downstream clock gate cell.
// Define UCDP_CLK_GATE_CTRL_STAT_EN to add the saturating gate-event counter gate_cnt_o.
module ucdp_clk_gate_ctrl
    import ucdp_clk_gate_ctrl_pkg::*;
#(
    parameter int IdleWidth  = DefaultIdleWidth,
    parameter int WakeCycles = DefaultWakeCycles,
    parameter int StatWidth  = DefaultStatWidth
) (
    input  logic                 main_clk_i,
    input  logic                 main_rst_an_i,
    input  logic                 idle_i,
    input  logic                 wake_i,
    input  logic                 force_en_i,
    input  logic [IdleWidth-1:0] idle_thresh_i,
    output logic                 en_o,
    output logic                 gated_o,
    output logic                 ready_o
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
    ,
    output logic [StatWidth-1:0] gate_cnt_o
`endif
);

    localparam int                    WakeCntW = wake_cnt_width(WakeCycles);
    localparam logic [WakeCntW-1:0]   WakeLast = WakeCntW'(WakeCycles - 1);
    localparam logic [IdleWidth-1:0]  IdleOne  = IdleWidth'(1);
    localparam logic [IdleWidth-1:0]  IdleMax  = '1;

    gate_state_e          state_reg;
    logic [WakeCntW-1:0]  wake_cnt_reg;
    logic [IdleWidth-1:0] idle_cnt_reg;
    logic                 en_reg;
    logic                 gated_reg;
    logic                 ready_reg;

    logic gate_cond;
    logic idle_term;
    logic gate_event;

    // Threshold is sampled live; >= lets a lowered threshold take effect immediately.
    assign gate_cond  = idle_i & ~wake_i & ~force_en_i & (idle_thresh_i != '0);
    assign idle_term  = (idle_cnt_reg >= (idle_thresh_i - IdleOne));
    assign gate_event = (state_reg == ST_RUN) & gate_cond & idle_term;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_reg    <= ST_WAKE;
            wake_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            en_reg       <= 1'b1;
            gated_reg    <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_WAKE: begin
                    if (wake_cnt_reg == WakeLast) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (gate_event) begin
                        state_reg    <= ST_GATED;
                        idle_cnt_reg <= '0;
                        en_reg       <= 1'b0;
                        gated_reg    <= 1'b1;
                        ready_reg    <= 1'b0;
                    end else if (!gate_cond) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg != IdleMax) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                ST_GATED: begin
                    // Gated domain is frozen, so idle_i carries no information here.
                    if (wake_i || force_en_i) begin
                        state_reg    <= ST_WAKE;
                        wake_cnt_reg <= '0;
                        en_reg       <= 1'b1;
                        gated_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_WAKE;
                    wake_cnt_reg <= '0;
                    idle_cnt_reg <= '0;
                    en_reg       <= 1'b1;
                    gated_reg    <= 1'b0;
                    ready_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign en_o    = en_reg;
    assign gated_o = gated_reg;
    assign ready_o = ready_reg;

`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
    logic [StatWidth-1:0] gate_cnt_reg;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            gate_cnt_reg <= '0;
        end else if (gate_event && (gate_cnt_reg != '1)) begin
            gate_cnt_reg <= gate_cnt_reg + 1'b1;
        end
    end

    assign gate_cnt_o = gate_cnt_reg;
`else
    if (StatWidth > 0) begin : g_no_stat
    end
`endif

endmodule

// File: tb/tb_ucdp_clk_gate_ctrl.sv
// Directed plus randomized bench for ucdp_clk_gate_ctrl against a cycle-level reference model.
module tb_ucdp_clk_gate_ctrl;

    localparam int IdleWidth  = 8;
    localparam int WakeCycles = 2;
    localparam int StatWidth  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 idle = 1'b0;
    logic                 wake = 1'b0;
    logic                 force_en = 1'b0;
    logic [IdleWidth-1:0] thresh = '0;
    logic                 en;
    logic                 gated;
    logic                 ready;
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
    logic [StatWidth-1:0] gate_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: gated flag, cycles since last wake-up, length of current idle streak.
    bit          m_gated;
    int unsigned m_age;
    int unsigned m_streak;
    int unsigned m_count;

    always #5 clk = ~clk;

    ucdp_clk_gate_ctrl #(
        .IdleWidth (IdleWidth),
        .WakeCycles(WakeCycles),
        .StatWidth (StatWidth)
    ) dut (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .idle_i       (idle),
        .wake_i       (wake),
        .force_en_i   (force_en),
        .idle_thresh_i(thresh),
        .en_o         (en),
        .gated_o      (gated),
        .ready_o      (ready)
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
        ,
        .gate_cnt_o   (gate_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_gated  = 1'b0;
        m_age    = 0;
        m_streak = 0;
        m_count  = 0;
    endtask

    task automatic model_step();
        if (m_gated) begin
            if (wake || force_en) begin
                m_gated = 1'b0;
                m_age   = 0;
            end
        end else if (m_age < WakeCycles) begin
            m_age++;
        end else if (idle && !wake && !force_en && thresh != 0) begin
            m_streak++;
            if (m_streak >= thresh) begin
                m_gated  = 1'b1;
                m_streak = 0;
                if (m_count < (2 ** StatWidth) - 1) m_count++;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_en"},    32'(en),    32'(!m_gated));
        check({tag, "_gated"}, 32'(gated), 32'(m_gated));
        check({tag, "_ready"}, 32'(ready), 32'(!m_gated && m_age >= WakeCycles));
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
        check({tag, "_cnt"},   32'(gate_cnt), m_count);
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        // Reset held: clock enabled, not ready.
        model_reset();
        rst_n = 1'b0;
        #2;
        check_outputs("rst_hold");
        ticks("rst_hold", 2);
        rst_n = 1'b1;
        check("rel_c0_ready", 32'(ready), 32'd0);
        tick("rel_c1");
        check("rel_c1_ready", 32'(ready), 32'd0);
        tick("rel_c2");
        check("rel_c2_ready", 32'(ready), 32'd1);
        check("rel_c2_en", 32'(en), 32'd1);

        // Threshold 4, idle held: enable first low in cycle 4.
        thresh = 8'd4;
        idle   = 1'b1;
        ticks("thr4", 3);
        check("thr4_c3_en", 32'(en), 32'd1);
        tick("thr4");
        check("thr4_c4_en", 32'(en), 32'd0);
        check("thr4_c4_gated", 32'(gated), 32'd1);
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
        check("thr4_cnt", 32'(gate_cnt), 32'd1);
`endif

        // One-cycle wake pulse; idle low so the next test starts from a clean streak.
        ticks("gated_idle", 3);
        wake = 1'b1;
        idle = 1'b0;
        tick("wake_pulse");
        wake = 1'b0;
        check("wake_en_next", 32'(en), 32'd1);
        tick("wake_settle");
        check("wake_ready_c1", 32'(ready), 32'd0);
        tick("wake_settle");
        check("wake_ready_c2", 32'(ready), 32'd1);

        // Idle broken after 3 cycles: gating needs 4 further consecutive idle cycles.
        idle = 1'b1;
        ticks("brk", 3);
        idle = 1'b0;
        tick("brk");
        idle = 1'b1;
        ticks("brk", 3);
        check("brk_c7_en", 32'(en), 32'd1);
        tick("brk");
        check("brk_c8_en", 32'(en), 32'd0);
`ifdef UCDP_CLK_GATE_CTRL_STAT_EN
        check("brk_cnt", 32'(gate_cnt), 32'd2);
`endif

        // force_en wakes from GATED and then inhibits gating.
        force_en = 1'b1;
        tick("force_wake");
        check("force_wake_en", 32'(en), 32'd1);
        ticks("force_hold", 100);
        check("force_hold_en", 32'(en), 32'd1);
        force_en = 1'b0;
        thresh   = 8'd0;
        ticks("thr0_hold", 100);
        check("thr0_hold_en", 32'(en), 32'd1);

        // Threshold dropped to 0 mid-count clears the streak.
        thresh = 8'd5;
        ticks("thr_mid", 3);
        thresh = 8'd0;
        tick("thr_mid0");
        thresh = 8'd5;
        ticks("thr_mid", 4);
        check("thr_mid_en", 32'(en), 32'd1);
        tick("thr_mid");
        check("thr_mid_gate", 32'(en), 32'd0);

        // Wake back, then lower the threshold mid-count.
        wake = 1'b1;
        tick("wake2");
        wake = 1'b0;
        idle = 1'b0;
        ticks("wake2", 2);
        idle   = 1'b1;
        thresh = 8'd10;
        ticks("lower", 5);
        thresh = 8'd3;
        tick("lower");
        check("lower_en", 32'(en), 32'd0);

        // wake_i coincident with the terminal idle count keeps the clock running.
        force_en = 1'b1;
        tick("coinc_wake");
        force_en = 1'b0;
        idle = 1'b0;
        ticks("coinc_settle", 2);
        thresh = 8'd2;
        idle   = 1'b1;
        tick("coinc");
        wake = 1'b1;
        tick("coinc_term");
        wake = 1'b0;
        check("coinc_en", 32'(en), 32'd1);
        check("coinc_ready", 32'(ready), 32'd1);
        ticks("coinc_after", 2);
        check("coinc_after_en", 32'(en), 32'd0);

        // Asynchronous reset while gated: enable returns before the next edge.
        rst_n = 1'b0;
        #1;
        check("areset_en", 32'(en), 32'd1);
        check("areset_ready", 32'(ready), 32'd0);
        check("areset_gated", 32'(gated), 32'd0);
        model_reset();
        tick("areset_hold");
        rst_n = 1'b1;
        ticks("areset_rel", 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            idle     = ($urandom_range(0, 9) < 8);
            wake     = ($urandom_range(0, 24) == 0);
            force_en = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) thresh = 8'($urandom_range(0, 6));
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
